// File: rtl/note_detector_pkg.sv
// Shared types and width helpers for the multi-note correlation detector.
package note_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        LOAD = 2'd2
    } state_t;

    function automatic int prod_w(input int int_in, input int frac_in, input int ref_w);
        return int_in + frac_in + ref_w;
    endfunction

    function automatic int acc_w(input int prod, input int window_log2);
        return prod + window_log2;
    endfunction

endpackage

// File: rtl/note_detector_lane.sv
// One correlation channel: full-precision multiply-accumulate, cleared at the
// window boundary, where the saturating magnitude of the final sum is snapshotted.
module note_detector_lane
    import note_detector_pkg::*;
#(
    parameter int int_in_p      = 2,
    parameter int frac_in_p     = 10,
    parameter int ref_width_p   = 12,
    parameter int window_log2_p = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [int_in_p+frac_in_p-1:0]          i_audio,
    input  logic [ref_width_p-1:0]                 i_ref,
    input  logic                                   i_accept,
    input  logic                                   i_boundary,
    output logic [acc_w(prod_w(int_in_p, frac_in_p, ref_width_p), window_log2_p)-1:0] o_snap
);

    localparam int PROD_W = prod_w(int_in_p, frac_in_p, ref_width_p);
    localparam int ACC_W  = acc_w(PROD_W, window_log2_p);
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic        [ACC_W-1:0]  w_abs;
    logic signed [ACC_W-1:0]  r_acc;
    logic        [ACC_W-1:0]  r_snap;

    assign w_prod     = $signed(i_audio) * $signed(i_ref);
    assign w_prod_ext = {{window_log2_p{w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // Negating the most-negative value would wrap, so it clamps to the largest positive.
    always_comb begin
        w_abs = w_sum;
        if (w_sum[ACC_W-1]) begin
            w_abs = (w_sum == ACC_MIN) ? ACC_MAX : -w_sum;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else if (i_accept) begin
            if (i_boundary) begin
                r_acc  <= '0;
                r_snap <= w_abs;
            end else begin
                r_acc  <= w_sum;
            end
        end
    end

    assign o_snap = r_snap;

endmodule

// File: rtl/note_detector.sv
// Correlates line-in against per-note references each window, then scans the
// snapshots for the strongest note and presents it on a valid/ready output.
module note_detector
    import note_detector_pkg::*;
#(
    parameter int num_notes_p   = 7,
    parameter int int_in_p      = 2,
    parameter int frac_in_p     = 10,
    parameter int ref_width_p   = 12,
    parameter int window_log2_p = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [int_in_p+frac_in_p-1:0]          audio_i,
    input  logic [num_notes_p*ref_width_p-1:0]     ref_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [acc_w(prod_w(int_in_p, frac_in_p, ref_width_p), window_log2_p)-1:0] threshold_i,
    output logic [$clog2(num_notes_p)-1:0]         note_o,
    output logic [acc_w(prod_w(int_in_p, frac_in_p, ref_width_p), window_log2_p)-1:0] mag_o,
    output logic                                   present_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic                                   overrun_o
);

    localparam int PROD_W = prod_w(int_in_p, frac_in_p, ref_width_p);
    localparam int ACC_W  = acc_w(PROD_W, window_log2_p);
    localparam int NOTE_W = $clog2(num_notes_p);
    localparam logic [NOTE_W-1:0] IDX_LAST = NOTE_W'(num_notes_p - 1);

    logic                     w_accept;
    logic                     w_boundary;
    logic [window_log2_p-1:0] r_cnt;
    logic [ACC_W-1:0]         w_snap [num_notes_p];

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NOTE_W-1:0]        r_idx;
    logic [NOTE_W-1:0]        r_best_idx;
    logic [ACC_W-1:0]         r_best_mag;
    logic [NOTE_W-1:0]        r_note;
    logic [ACC_W-1:0]         r_mag;
    logic                     r_present;
    logic                     r_valid;
    logic                     r_overrun;

    assign ready_o    = !reset_i;
    assign w_accept   = valid_i && ready_o;
    assign w_boundary = w_accept && (r_cnt == '1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < num_notes_p; k++) begin : g_lane
        note_detector_lane #(
            .int_in_p      (int_in_p),
            .frac_in_p     (frac_in_p),
            .ref_width_p   (ref_width_p),
            .window_log2_p (window_log2_p)
        ) u_lane (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .i_audio    (audio_i),
            .i_ref      (ref_i[k*ref_width_p +: ref_width_p]),
            .i_accept   (w_accept),
            .i_boundary (w_boundary),
            .o_snap     (w_snap[k])
        );
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_boundary) w_state_nxt = SCAN;
            SCAN:    if (r_idx == IDX_LAST) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on equal magnitudes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_mag <= '0;
            r_note     <= '0;
            r_mag      <= '0;
            r_present  <= 1'b0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_boundary) begin
                        r_idx      <= '0;
                        r_best_idx <= '0;
                        r_best_mag <= '0;
                    end
                end
                SCAN: begin
                    if (w_snap[r_idx] > r_best_mag) begin
                        r_best_idx <= r_idx;
                        r_best_mag <= w_snap[r_idx];
                    end
                    r_idx <= r_idx + 1'b1;
                end
                LOAD: begin
                    r_note    <= r_best_idx;
                    r_mag     <= r_best_mag;
                    r_present <= (r_best_mag >= threshold_i);
                    r_valid   <= 1'b1;
                    r_overrun <= r_valid && !ready_i;
                end
                default: ;
            endcase
        end
    end

    assign note_o    = r_note;
    assign mag_o     = r_mag;
    assign present_o = r_present;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector with 4 notes and 16-sample windows.
module tb_note_detector;

    localparam int N     = 4;
    localparam int RW    = 12;
    localparam int ACC_W = 28;
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic              clk = 1'b0;
    logic              reset_i;
    logic [11:0]       audio_i;
    logic [N*RW-1:0]   ref_i;
    logic              valid_i;
    logic              ready_o;
    logic [ACC_W-1:0]  threshold_i;
    logic [1:0]        note_o;
    logic [ACC_W-1:0]  mag_o;
    logic              present_o;
    logic              valid_o;
    logic              ready_i;
    logic              overrun_o;

    int n_chk  = 0;
    int n_err  = 0;
    int ov_cnt = 0;
    int ov0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun_o) ov_cnt <= ov_cnt + 1;
    end

    note_detector #(
        .num_notes_p   (N),
        .int_in_p      (2),
        .frac_in_p     (10),
        .ref_width_p   (RW),
        .window_log2_p (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .audio_i     (audio_i),
        .ref_i       (ref_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .threshold_i (threshold_i),
        .note_o      (note_o),
        .mag_o       (mag_o),
        .present_o   (present_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .overrun_o   (overrun_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*RW-1:0] mkref(input logic [11:0] r0, input logic [11:0] r1,
                                              input logic [11:0] r2, input logic [11:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic feed(input int n, input logic [11:0] aud, input logic [N*RW-1:0] refs,
                        input int maxgap);
        for (int i = 0; i < n; i++) begin
            audio_i = aud;
            ref_i   = refs;
            valid_i = 1'b1;
            @(posedge clk); #1;
            valid_i = 1'b0;
            if (maxgap > 0 && i != n - 1) begin
                repeat ($urandom_range(0, maxgap)) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic wait_result(input bit check_lat);
        int cyc = 0;
        while (!valid_o && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (check_lat) chk("latency", cyc, 5);
        chk("valid_o", valid_o, 1);
    endtask

    task automatic check_result(input string tag, input int note, input int mag, input bit pres);
        chk({tag, ".note"}, note_o, note);
        chk({tag, ".mag"}, mag_o, mag);
        chk({tag, ".present"}, present_o, pres);
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        chk("consume", valid_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i     = 1'b1;
        valid_i     = 1'b0;
        audio_i     = '0;
        ref_i       = '0;
        ready_i     = 1'b0;
        threshold_i = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready_o", ready_o, 0);
        chk("rst.valid_o", valid_o, 0);
        chk("rst.overrun", overrun_o, 0);
        check_result("rst", 0, 0, 0);
        reset_i = 1'b0;
        #1;
        chk("ready_o", ready_o, 1);

        // single tone on channel 2
        ov0 = ov_cnt;
        feed(16, 12'd512, mkref(0, 0, 12'd2047, 0), 0);
        wait_result(1);
        check_result("tone", 2, 16769024, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("hold.valid", valid_o, 1);
        chk("hold.note", note_o, 2);
        chk("tone.ovr", ov_cnt - ov0, 0);
        consume();

        // negative operands
        feed(16, 12'h800, mkref(0, 12'h800, 0, 0), 0);
        wait_result(1);
        check_result("neg", 1, 67108864, 1);
        consume();

        // tie between channels 1 and 3
        feed(16, 12'd100, mkref(0, 12'd1000, 0, 12'd1000), 0);
        wait_result(1);
        check_result("tie", 1, 1600000, 1);
        consume();

        // all references silent, nonzero threshold
        threshold_i = 5;
        feed(16, 12'd700, mkref(0, 0, 0, 0), 0);
        wait_result(1);
        check_result("zero", 0, 0, 0);
        consume();

        // threshold one above the magnitude
        threshold_i = 16769025;
        feed(16, 12'd512, mkref(0, 0, 12'd2047, 0), 0);
        wait_result(1);
        check_result("thr_hi", 2, 16769024, 0);
        consume();

        // random stalls, threshold exactly equal to the magnitude
        threshold_i = 16769024;
        feed(16, 12'd512, mkref(0, 0, 12'd2047, 0), 3);
        wait_result(1);
        check_result("stall", 2, 16769024, 1);

        // second window with the first result unconsumed
        threshold_i = 1;
        ov0 = ov_cnt;
        feed(16, 12'h800, mkref(0, 12'h800, 0, 0), 0);
        repeat (7) begin @(posedge clk); #1; end
        chk("ovr.count", ov_cnt - ov0, 1);
        chk("ovr.valid", valid_o, 1);
        check_result("ovr", 1, 67108864, 1);

        // ready asserted during the LOAD cycle
        ov0 = ov_cnt;
        feed(16, 12'd100, mkref(0, 12'd1000, 0, 12'd1000), 0);
        repeat (4) begin @(posedge clk); #1; end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("ldrdy.count", ov_cnt - ov0, 0);
        chk("ldrdy.valid", valid_o, 1);
        check_result("ldrdy", 1, 1600000, 1);
        consume();

        // most-negative sum at the boundary saturates
        feed(15, 12'd0, mkref(0, 0, 0, 0), 0);
        audio_i = '0;
        ref_i   = '0;
        valid_i = 1'b1;
        force dut.g_lane[1].u_lane.w_sum = ACC_MIN;
        @(posedge clk); #1;
        valid_i = 1'b0;
        release dut.g_lane[1].u_lane.w_sum;
        wait_result(1);
        check_result("sat", 1, 134217727, 1);

        // reset mid-window with a result still pending
        feed(9, 12'd512, mkref(0, 0, 12'd2047, 0), 0);
        reset_i = 1'b1;
        #2;
        chk("mrst.ready_o", ready_o, 0);
        chk("mrst.valid_o", valid_o, 0);
        chk("mrst.overrun", overrun_o, 0);
        check_result("mrst", 0, 0, 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        feed(16, 12'd512, mkref(0, 0, 12'd2047, 0), 0);
        wait_result(1);
        check_result("post_rst", 2, 16769024, 1);
        consume();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
